// File: rtl/alu_defs.sv
// Shared ALU operation codes plus the multiplier sequencer's state encoding.
package alu_defs;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add unsigned multiplier controller driving an external ALU.
module mul_seq_ctrl
  import alu_defs::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [W-1:0] mcand,
  input  logic [W-1:0] mplier,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_signal,
  output logic         alu_inv,
  input  logic [W-1:0] alu_sum,
  input  logic         alu_cout
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  mul_state_e     state_r, state_s;
  // The shifted-in carry lands in bit 2W-1, so the always-zero bit 2W is not stored.
  logic [2*W-1:0] p_r, p_s, p_shift_s;
  logic [W-1:0]   mcand_r, mcand_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           busy_s, done_s;
  logic [W-1:0]   hi_s, lo_s;

  assign p_shift_s = {alu_cout, alu_sum, p_r[W-1:1]};

  // Next-state, working-register and result computation.
  always_comb begin
    state_s = state_r;
    p_s     = p_r;
    mcand_s = mcand_r;
    cnt_s   = cnt_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    hi_s    = hi;
    lo_s    = lo;
    case (state_r)
      ST_IDLE: begin
        if (start && !kill) begin
          state_s = ST_RUN;
          p_s     = {{W{1'b0}}, mplier};
          mcand_s = mcand;
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_s = ST_IDLE;
        end else begin
          p_s   = p_shift_s;
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_s = ST_FIN;
            hi_s    = p_shift_s[2*W-1:W];
            lo_s    = p_shift_s[W-1:0];
            done_s  = 1'b1;
          end else begin
            busy_s = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, result and ALU-drive registers; ALU operands are set up one cycle ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      p_r        <= {(2*W){1'b0}};
      mcand_r    <= {W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= {W{1'b0}};
      lo         <= {W{1'b0}};
      alu_a      <= {W{1'b0}};
      alu_b      <= {W{1'b0}};
      alu_signal <= ALU_AND;
      alu_inv    <= 1'b0;
    end else begin
      state_r <= state_s;
      p_r     <= p_s;
      mcand_r <= mcand_s;
      cnt_r   <= cnt_s;
      busy    <= busy_s;
      done    <= done_s;
      hi      <= hi_s;
      lo      <= lo_s;
      alu_inv <= 1'b0;
      if (state_s == ST_RUN) begin
        alu_signal <= ALU_ADD;
        alu_a      <= p_s[2*W-1:W];
        alu_b      <= p_s[0] ? mcand_s : {W{1'b0}};
      end else begin
        alu_signal <= ALU_AND;
        alu_a      <= {W{1'b0}};
        alu_b      <= {W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural ALU attached to the alu_* ports.
module tb_mul_seq_ctrl;
  import alu_defs::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill;
  logic [W-1:0] mcand, mplier;
  logic         busy, done;
  logic [W-1:0] hi, lo, alu_a, alu_b, alu_sum;
  logic [1:0]   alu_signal;
  logic         alu_inv, alu_cout;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal), .alu_inv(alu_inv),
    .alu_sum(alu_sum), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    logic [W-1:0] b_eff;
    b_eff    = alu_inv ? ~alu_b : alu_b;
    alu_cout = 1'b0;
    alu_sum  = {W{1'b0}};
    case (alu_signal)
      2'b00: alu_sum = alu_a & b_eff;
      2'b01: alu_sum = alu_a | b_eff;
      2'b10: {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, b_eff} + {{W{1'b0}}, alu_inv};
      2'b11: alu_sum = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(b_eff))};
      default: alu_sum = {W{1'b0}};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; mcand = '0; mplier = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_result hi=%h lo=%h expected 0/0", hi, lo);
    end
    checks++;
    if ({alu_signal, alu_inv, alu_a, alu_b} !== 67'h0) begin
      errors++; $display("FAIL reset_alu sig=%b inv=%b a=%h b=%h expected all 0", alu_signal, alu_inv, alu_a, alu_b);
    end
  endtask

  task automatic test_basic();
    mcand = 32'd3; mplier = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL basic_busy t+%0d busy=%b done=%b expected 1/0", k, busy, done);
      end
      checks++;
      if (alu_signal !== 2'b10 || alu_inv !== 1'b0) begin
        errors++; $display("FAIL basic_aluop t+%0d sig=%b inv=%b expected 10/0", k, alu_signal, alu_inv);
      end
      if (k == 1) begin
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd3) begin
          errors++; $display("FAIL basic_first_operands a=%h b=%h expected 0/3", alu_a, alu_b);
        end
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done t+33 done=%b busy=%b expected 1/0", done, busy);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      errors++; $display("FAIL basic_result hi=%h lo=%h expected 0/f", hi, lo);
    end
    checks++;
    if ({alu_signal, alu_a, alu_b} !== 66'h0) begin
      errors++; $display("FAIL basic_alu_idle sig=%b a=%h b=%h expected 0", alu_signal, alu_a, alu_b);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_carry();
    logic saw_cout;
    saw_cout = 1'b0;
    mcand = 32'hFFFF_FFFF; mplier = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      saw_cout = saw_cout | alu_cout;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL carry_done done=%b expected 1", done);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++; $display("FAIL carry_result hi=%h lo=%h expected fffffffe/00000001", hi, lo);
    end
    checks++;
    if (saw_cout !== 1'b1) begin
      errors++; $display("FAIL carry_cout_seen got=%b expected 1", saw_cout);
    end
    tick();
  endtask

  task automatic test_zero();
    mcand = 32'd0; mplier = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      checks++;
      if (alu_b !== 32'd0) begin
        errors++; $display("FAIL zero_alu_b t+%0d b=%h expected 0", k, alu_b);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL zero_result done=%b hi=%h lo=%h expected 1/0/0", done, hi, lo);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int dones;
    dones = 0;
    mcand = 32'd7; mplier = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (k == 5) begin
        start = 1'b1; mcand = 32'h0000_DEAD; mplier = 32'h0000_BEEF;
      end else begin
        start = 1'b0;
      end
      dones += int'(done);
      tick();
    end
    checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd63) begin
      errors++; $display("FAIL ignore_result done=%b hi=%h lo=%h expected 1/0/3f", done, hi, lo);
    end
    dones += int'(done);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ignore_start_in_fin busy=%b expected 0", busy);
    end
    for (int k = 0; k < 40; k++) begin
      dones += int'(done);
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL ignore_single_done count=%0d expected 1", dones);
    end
    checks++;
    if (lo !== 32'd63) begin
      errors++; $display("FAIL ignore_hold lo=%h expected 3f", lo);
    end
  endtask

  task automatic test_kill();
    int dones;
    dones = 0;
    mcand = 32'd3; mplier = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < W + 2; k++) tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      errors++; $display("FAIL kill_prior hi=%h lo=%h expected 0/f", hi, lo);
    end
    mcand = 32'h100; mplier = 32'h100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL kill_busy t+11 busy=%b done=%b expected 0/0", busy, done);
    end
    for (int k = 0; k < 40; k++) begin
      dones += int'(done);
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL kill_no_done count=%0d expected 0", dones);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      errors++; $display("FAIL kill_hold hi=%h lo=%h expected 0/f", hi, lo);
    end
    mcand = 32'd2; mplier = 32'd6; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL kill_beats_start busy=%b expected 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) tick();
    checks++;
    if (done !== 1'b1 || lo !== 32'd12 || hi !== 32'd0) begin
      errors++; $display("FAIL kill_restart done=%b hi=%h lo=%h expected 1/0/c", done, hi, lo);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int dones;
    dones = 0;
    mcand = 32'd11; mplier = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      errors++; $display("FAIL rst_mid_outputs busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    checks++;
    if ({alu_signal, alu_inv, alu_a, alu_b} !== 67'h0) begin
      errors++; $display("FAIL rst_mid_alu sig=%b a=%h b=%h expected all 0", alu_signal, alu_a, alu_b);
    end
    for (int k = 0; k < 40; k++) begin
      dones += int'(done) + int'(busy);
      tick();
    end
    checks++;
    if (dones != 0 || lo !== 32'd0) begin
      errors++; $display("FAIL rst_mid_quiet activity=%0d lo=%h expected 0/0", dones, lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignored_start();
    test_kill();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: W, default 32, operand width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: kill  input  1  pipeline flush; aborts an operation in progress.
REQ-006 Port: mcand  input  W  multiplicand (unsigned), captured on an accepted start.
REQ-007 Port: mplier  input  W  multiplier (unsigned), captured on an accepted start.
REQ-008 Port: busy  output  1  high while iterating.
REQ-009 Port: done  output  1  one-cycle pulse when the result registers update.
REQ-010 Port: hi  output  W  upper half of the last completed product.
REQ-011 Port: lo  output  W  lower half of the last completed product.
REQ-012 Port: alu_a  output  W  ALU operand A, driven with the partial-product high half.
REQ-013 Port: alu_b  output  W  ALU operand B: mcand if the working LSB is 1, else 0.
REQ-014 Port: alu_signal  output  2  ALU operation select (00 AND, 01 OR, 10 ADD, 11 SLT).
REQ-015 Port: alu_inv  output  1  ALU B-invert and carry-in; always 0 from this block.
REQ-016 Port: alu_sum  input  W  ALU result, combinational from alu_a/alu_b.
REQ-017 Port: alu_cout  input  1  ALU MSB carry-out.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RUN and FIN.
- IDLE -> RUN on start=1.
- RUN -> FIN after the 32nd (W-th) iteration.
- FIN -> IDLE unconditionally.
REQ-019 An accepted start (cycle t) SHALL load:
- working register P[2W:0] = {1'b0, W'b0, mplier};
- mcand into an internal register;
- iteration counter = 0.
REQ-020 In RUN, each cycle SHALL drive:
- alu_signal = 10, alu_inv = 0;
- alu_a = P[2W-1:W];
- alu_b = P[0] ? mcand_reg : 0.
REQ-021 In RUN, each cycle SHALL update P <= {alu_cout, alu_sum, P[W-1:1]}, a one-bit right shift of the sum, and increment the counter.
REQ-022 busy SHALL be 1 exactly in cycles t+1 .. t+W; the counter SHALL be $clog2(W)+1 bits and SHALL NOT wrap mid-operation.
REQ-023 In FIN (cycle t+W+1), the block SHALL load hi <= P[2W-1:W] and lo <= P[W-1:0] and assert done for that cycle only; result latency is W+1 cycles from start.
REQ-024 hi and lo SHALL hold their value until the next completed operation; they are never changed by start, kill or an aborted operation.
REQ-025 start while busy or in FIN SHALL be ignored with no queuing.
REQ-026 kill in RUN SHALL return the FSM to IDLE next cycle:
- busy = 0 and no done pulse;
- hi and lo unchanged.
REQ-027 kill in FIN SHALL be ignored; the completion proceeds. kill and start together in IDLE: kill SHALL win and start is dropped.
REQ-028 Outside RUN, ALU outputs SHALL be alu_signal=00, alu_inv=0, alu_a=0, alu_b=0.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL clear state=IDLE, busy=0, done=0, hi=0, lo=0, P=0, counter=0 and mcand_reg=0, regardless of state.
REQ-030 rst SHALL take priority over start and kill; a reset mid-RUN SHALL discard the operation with no done.

Structure
REQ-031 The ALU operation codes (AND/OR/ADD/SLT) SHALL live in the shared package alu_defs and be used by both this block and the ALU.
REQ-032 The block SHALL be a single module with no sub-modules; the ALU is instantiated by the parent and connected through the alu_* ports.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- mcand=3, mplier=5, start at t -> busy t+1..t+32; done at t+33; hi=0, lo=15.
- 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; exercises alu_cout.
- 0 x 0x12345678 after a prior result -> hi=0, lo=0; alu_b=0 every RUN cycle.
- start pulsed at t+5 during 7x9 -> ignored; single done at t+33 with lo=63.
- kill at t+10 after prior result 15 -> busy=0 at t+11; no done; hi/lo stay 0/15; new start works.
- rst at t+20 mid-operation -> all outputs 0 next cycle; no done.
